ucie_ctl_rx_flit_assembler: RTL

Downstream neighbour of the UCIe controller RX top: consumes the per-cycle FDI data beats (`o_fdi_data`/`o_fdi_data_valid`/`o_overflow_detected`) and packs `BEATS` consecutive beats into one flit. Completed flits go into a 2-entry flit FIFO and are presented to the protocol layer with a valid/ready handshake. The RX top has no backpressure, so a flit that finds the FIFO full is dropped and counted. Overflow and idle events from the RX side abort the partial flit.

---
 rtl/ucie_ctl_rx_flit_assembler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ucie_ctl_rx_flit_assembler.sv
// ucie_ctl_rx_flit_assembler: packs BEATS consecutive FDI beats into one flit and
// queues completed flits in a 2-entry FIFO. The FIFO drains over a valid/ready
// handshake. The upstream has no backpressure, so a flit that finds the FIFO
// full is dropped and counted. Overflow and idle events abort the partial flit.
module ucie_ctl_rx_flit_assembler #(
  parameter  int NBYTES = 32,
  parameter  int BEATS  = 4,
  localparam int CW     = $clog2(BEATS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_state_request,
  input  logic [NBYTES-1:0]       i_fdi_data,
  input  logic                    i_fdi_data_valid,
  input  logic                    i_overflow_detected,
  output logic [NBYTES*BEATS-1:0] o_flit_data,
  output logic                    o_flit_valid,
  input  logic                    i_flit_ready,
  output logic                    o_flit_drop,
  output logic [CW-1:0]           o_beat_count,
  output logic [7:0]              o_drop_count
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESYNC} state_t;

  state_t                        state, state_nxt;
  logic [BEATS-2:0][NBYTES-1:0]  asm_q;     // the last slot is never stored; it completes the flit
  logic [NBYTES*BEATS-1:0]       flit_w;
  logic [NBYTES*BEATS-1:0]       tail_q;
  logic [1:0]                    fcnt, fcnt_nxt;
  logic                          accept, complete, clear, abort_drop;
  logic                          pop, push_ok, full_drop, drop_evt;

  // Decode this cycle's action from the FSM state. Priority in ACTIVE:
  // idle request, then overflow, then beat accept.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    complete   = 1'b0;
    clear      = 1'b0;
    abort_drop = 1'b0;
    case (state)
      IDLE: if (i_state_request) state_nxt = ACTIVE;
      ACTIVE: begin
        if (!i_state_request) begin
          state_nxt  = IDLE;
          clear      = 1'b1;
          abort_drop = (o_beat_count != '0);
        end else if (i_overflow_detected) begin
          state_nxt  = RESYNC;
          clear      = 1'b1;
          abort_drop = 1'b1;
        end else if (i_fdi_data_valid) begin
          accept   = 1'b1;
          complete = (o_beat_count == CW'(BEATS-1));
        end
      end
      RESYNC: begin
        if (!i_state_request)                              state_nxt = IDLE;
        else if (!i_fdi_data_valid && !i_overflow_detected) state_nxt = ACTIVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Completed flit is the stored slots plus the beat arriving now.
  assign flit_w    = {i_fdi_data, asm_q};
  assign pop       = o_flit_valid & i_flit_ready;
  assign push_ok   = complete & ((fcnt != 2'd2) | pop);
  assign full_drop = complete & (fcnt == 2'd2) & ~pop;
  assign drop_evt  = abort_drop | full_drop;
  assign fcnt_nxt  = fcnt + {1'b0, push_ok} - {1'b0, pop};

  // FSM state and beat counter; the counter wraps to 0 on the completing beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      o_beat_count <= '0;
    end else begin
      state <= state_nxt;
      if (clear)       o_beat_count <= '0;
      else if (accept) o_beat_count <= o_beat_count + CW'(1);
    end
  end

  // Assembly slots: each slot captures the beat when the count points at it.
  for (genvar b = 0; b < BEATS-1; b++) begin : g_slot
    // Slot b write.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                 asm_q[b] <= '0;
      else if (accept && o_beat_count == CW'(b)) asm_q[b] <= i_fdi_data;
    end
  end

  // Two-entry FIFO; the head register is the output bus, so it holds during a stall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_flit_data  <= '0;
      tail_q       <= '0;
      fcnt         <= 2'd0;
      o_flit_valid <= 1'b0;
    end else begin
      fcnt         <= fcnt_nxt;
      o_flit_valid <= (fcnt_nxt != 2'd0);
      case (fcnt)
        2'd0: if (push_ok) o_flit_data <= flit_w;
        2'd1: begin
          if (pop && push_ok) o_flit_data <= flit_w;
          else if (push_ok)   tail_q      <= flit_w;
        end
        default: begin
          if (pop) begin
            o_flit_data <= tail_q;
            if (push_ok) tail_q <= flit_w;
          end
        end
      endcase
    end
  end

  // Drop pulse and saturating drop counter; at most one event per cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_flit_drop  <= 1'b0;
      o_drop_count <= 8'd0;
    end else begin
      o_flit_drop <= drop_evt;
      if (drop_evt && o_drop_count != 8'hFF) o_drop_count <= o_drop_count + 8'd1;
    end
  end

endmodule
